// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that moves whole messages from NUM_REQ byte requesters into a uart_tx
// buffer under credit flow control. Define UART_TX_ARBITER_TIMEOUT_EN to add a stall timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BUF_DEPTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 put,
  output logic [7:0]           data,
  input  logic                 empty,
  output logic                 timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || BUF_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter value");
  end

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] grant_d;
  logic [IW-1:0]      last_q;
  logic               put_q;
  logic [7:0]         data_q;
  logic [CW-1:0]      credit_q;
  logic [CW-1:0]      credit_d;
  logic [CW:0]        credit_sum;
  logic               credit_ok;
  logic               acc_valid;
  logic               acc_last;
  logic [7:0]         acc_byte;
  logic               accept;
  logic               win_found;
  logic [IW-1:0]      win_idx;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_q;
  logic          timeout_q;
  logic          stall_hit;

  assign stall_hit = !acc_valid && (stall_q == SW'(TIMEOUT_CYCLES - 1));
  assign timeout   = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // The byte written this cycle still counts against the limit.
  assign credit_sum = {1'b0, credit_q} + {{CW{1'b0}}, put_q};
  assign credit_ok  = credit_sum < (CW+1)'(BUF_DEPTH);
  assign credit_d   = put_q ? credit_q + CW'(1) : (empty ? '0 : credit_q);

  assign req_ready = (state_q == XFER && credit_ok) ? grant_q : '0;
  assign accept    = (state_q == XFER) && credit_ok && acc_valid;
  assign grant_d   = NUM_REQ'(1) << win_idx;

  assign grant = grant_q;
  assign put   = put_q;
  assign data  = data_q;

  // last_q doubles as the current owner index while in XFER.
  always_comb begin
    acc_valid = 1'b0;
    acc_last  = 1'b0;
    acc_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_q == IW'(i)) begin
        acc_valid = req_valid[i];
        acc_last  = req_last[i];
        acc_byte  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!win_found && req_valid[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      put_q     <= 1'b0;
      data_q    <= '0;
      credit_q  <= '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      put_q    <= accept;
      credit_q <= credit_d;
      if (accept) data_q <= acc_byte;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= XFER;
            grant_q <= grant_d;
            last_q  <= win_idx;
          end
        end
        XFER: begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          stall_q <= acc_valid ? '0 : stall_q + SW'(1);
`endif
          if (accept && acc_last) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          else if (stall_hit) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a message-level reference model.
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int BUF = 16;
  localparam int TMO = 1024;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NR-1:0]     req_valid, req_last, req_ready, grant;
  logic [8*NR-1:0]   req_data;
  logic              put, empty, timeout;
  logic [7:0]        data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUF_DEPTH(BUF), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .put(put),
    .data(data), .empty(empty), .timeout(timeout)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: owner -1 means nobody holds the grant
  int        m_owner = -1, m_lastg = NR - 1, m_credit = 0, m_stall = 0, m_acc_idx = -1;
  bit        m_put = 1'b0, m_tmo = 1'b0, m_acc = 1'b0;
  logic [7:0] m_data = 8'h00;

  // requester traffic generator
  bit        gen_on = 1'b0;
  int        gen_vprob = 100, start_prob = 100, auto_len = 0, empty_mode = 1;
  bit [NR-1:0] auto_mask = '0;
  bit        g_act[NR];
  int        g_len[NR], g_pos[NR];

  // monitors
  int          n_put = 0, n_tmo = 0;
  bit          last_tmo = 1'b0;
  int          gorder[$];
  logic [NR-1:0] prev_grant = '0;

  task automatic start_msg(input int i, input int len);
    g_act[i] = 1'b1;
    g_pos[i] = 0;
    g_len[i] = len;
  endtask

  task automatic drive();
    if (gen_on) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = g_act[i] && ($urandom_range(99) < gen_vprob);
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = g_act[i] && (g_pos[i] == g_len[i] - 1);
      end
    end
    case (empty_mode)
      0:       empty = 1'b0;
      1:       empty = 1'b1;
      default: empty = ($urandom_range(9) == 0);
    endcase
  endtask

  task automatic model_step(input logic [NR-1:0] e_ready);
    bit found;
    m_acc = 1'b0;
    m_acc_idx = -1;
    if (!resetn) begin
      m_owner = -1; m_lastg = NR - 1; m_credit = 0; m_put = 1'b0;
      m_data = 8'h00; m_stall = 0; m_tmo = 1'b0;
      return;
    end
    m_tmo = 1'b0;
    if (m_owner >= 0 && req_valid[m_owner] && e_ready != '0) begin
      m_acc = 1'b1;
      m_acc_idx = m_owner;
    end
    m_credit = m_put ? m_credit + 1 : (empty ? 0 : m_credit);
    m_put = m_acc;
    if (m_acc) m_data = req_data[8*m_owner +: 8];
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_lastg + k) % NR;
        if (!found && req_valid[c]) begin
          found = 1'b1;
          m_owner = c;
          m_lastg = c;
        end
      end
    end else begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      m_stall = req_valid[m_owner] ? 0 : m_stall + 1;
`endif
      if (m_acc && req_last[m_owner]) m_owner = -1;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      else if (m_stall == TMO) begin
        m_owner = -1;
        m_stall = 0;
        m_tmo = 1'b1;
      end
`endif
    end
  endtask

  task automatic tick();
    logic [NR-1:0] e_grant, e_ready;
    drive();
    @(negedge clk);
    e_grant = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
    e_ready = (m_owner >= 0 && m_credit + int'(m_put) < BUF) ? e_grant : '0;
    if (chk_en) begin
      check("grant", grant, e_grant);
      check("req_ready", req_ready, e_ready);
      check("put", put, m_put);
      check("data", data, m_data);
      check("timeout", timeout, m_tmo);
    end
    if (put === 1'b1) n_put++;
    if (timeout === 1'b1) n_tmo++;
    last_tmo = (timeout === 1'b1);
    if (grant !== '0 && prev_grant === '0)
      for (int i = 0; i < NR; i++) if (grant[i]) gorder.push_back(i);
    prev_grant = grant;
    model_step(e_ready);
    if (gen_on && m_acc) begin
      g_pos[m_acc_idx]++;
      if (g_pos[m_acc_idx] == g_len[m_acc_idx]) g_act[m_acc_idx] = 1'b0;
    end
    if (gen_on)
      for (int i = 0; i < NR; i++)
        if (!g_act[i] && auto_mask[i] && $urandom_range(99) < start_prob)
          start_msg(i, auto_len > 0 ? auto_len : int'($urandom_range(6, 1)));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) g_act[i] = 1'b0;
    auto_mask = '0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_put = 0;
    n_tmo = 0;
    gorder.delete();
  endtask

  initial begin
    int tmo_at;
    resetn = 1'b0; req_valid = '0; req_data = '0; req_last = '0; empty = 1'b1;
    for (int i = 0; i < NR; i++) begin g_act[i] = 1'b0; g_len[i] = 1; g_pos[i] = 0; end
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_grant", grant, 0);
    check("rst_put", put, 0);
    resetn = 1'b1;

    // single 1-byte message from requester 0
    req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = 4'b0001;
    tick();
    check("r29_grant", grant, 1);
    check("r29_ready", req_ready, 1);
    tick();
    req_valid = '0; req_last = '0;
    check("r29_put", put, 1);
    check("r29_data", data, 8'h41);
    check("r29_grant_clr", grant, 0);
    tick();

    // everyone streaming 2-byte messages
    gen_on = 1'b1;
    do_reset();
    gen_vprob = 100; start_prob = 100; auto_len = 2; empty_mode = 1; auto_mask = '1;
    repeat (30) tick();
    for (int k = 0; k < 5; k++)
      check($sformatf("r30_order%0d", k), gorder.size() > k ? gorder[k] : -1, k % NR);

    // credit limit: 20 bytes into a 16-entry buffer
    do_reset();
    empty_mode = 0;
    start_msg(1, 20);
    repeat (40) tick();
    check("r31_puts16", n_put, 16);
    check("r31_ready0", req_ready, 0);
    check("r31_grant_kept", grant, 2);
    empty_mode = 1;
    tick();
    empty_mode = 0;
    repeat (30) tick();
    check("r31_puts20", n_put, 20);
    check("r31_grant_done", grant, 0);

    // stalled owner
    do_reset();
    empty_mode = 1;
    start_msg(2, 5);
    for (int k = 0; k < 20 && grant !== 4'b0100; k++) tick();
    check("r32_granted", grant, 4'b0100);
    gen_vprob = 0;
    tmo_at = -1;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (last_tmo && tmo_at < 0) tmo_at = k;
    end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    check("r32_tmo_cycle", tmo_at, TMO);
    check("r32_tmo_pulses", n_tmo, 1);
    check("r32_grant_rel", grant, 0);
`else
    check("r32_no_tmo", n_tmo, 0);
    check("r32_grant_held", grant, 4'b0100);
`endif
    gen_vprob = 100;

    // reset in the middle of a 5-byte message
    do_reset();
    start_msg(2, 5);
    for (int k = 0; k < 20 && g_pos[2] != 3; k++) tick();
    check("r33_three_acc", g_pos[2], 3);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("r33_put_after", put, 0);
    check("r33_grant_clr", grant, 0);
    check("r33_nput", n_put, 3);
    start_msg(0, 2);
    tick();
    check("r33_next_grant", grant, 1);

    // pending requests while requester 1 owns the grant
    do_reset();
    start_msg(1, 4);
    for (int k = 0; k < 10 && grant !== 4'b0010; k++) tick();
    tick();
    start_msg(3, 3);
    repeat (20) tick();
    check("r34_first", gorder.size() > 0 ? gorder[0] : -1, 1);
    check("r34_second", gorder.size() > 1 ? gorder[1] : -1, 3);

    // random traffic with random buffer drains and rare resets
    do_reset();
    auto_mask = '1; auto_len = 0; start_prob = 30; gen_vprob = 70; empty_mode = 2;
    for (int k = 0; k < 3000; k++) begin
      resetn = ($urandom_range(499) != 0);
      tick();
    end
    resetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter BUF_DEPTH, default 16: entry count of the downstream uart_tx buffer; used as the credit limit.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: stall limit; meaningful only under REQ-027.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  reset; synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  marks the final byte of a message; qualified by req_valid.
REQ-009 req_ready  output  NUM_REQ  per-requester byte accept, combinational.
REQ-010 grant  output  NUM_REQ  one-hot registered grant; all zero when idle.
REQ-011 put  output  1  registered one-cycle write strobe to the tx buffer.
REQ-012 data  output  8  registered byte to the tx buffer; valid when put=1.
REQ-013 empty  input  1  empty flag from the tx buffer.
REQ-014 timeout  output  1  registered one-cycle pulse on forced grant release.

Function
REQ-015 The block shall use two states: IDLE and XFER.
REQ-016 In IDLE, when any req_valid bit is 1, the block shall register grant to the round-robin winner and enter XFER on the next cycle; the search starts at last-granted index +1 and wraps at NUM_REQ-1 to 0.
REQ-017 In IDLE, req_ready shall be all zero.
REQ-018 In XFER, req_ready[i] shall equal grant[i] AND (credit_cnt + put < BUF_DEPTH).
REQ-019 A byte is accepted on a cycle where req_valid[i] and req_ready[i] are both 1; put=1 and data=that byte shall follow exactly one cycle later. Without an accept, put shall be 0 and data shall hold its previous value.
REQ-020 The grant shall hold across any number of bytes and stalls; accepting a byte with req_last=1 shall return the block to IDLE on the next cycle and clear grant. A requester therefore gets at least one IDLE cycle between consecutive messages.
REQ-021 credit_cnt, log2(BUF_DEPTH)+1 bits wide:
  - increments by 1 on each cycle with put=1;
  - is cleared to 0 on a cycle with empty=1 and put=0;
  - otherwise holds its value;
  - shall never exceed BUF_DEPTH.
REQ-022 When the credit limit is reached, req_ready shall be 0 and the grant shall be kept; transfer resumes once the buffer reports empty.
REQ-023 A requester that deasserts req_valid mid-message shall keep the grant (the timeout option in REQ-027 is the exception).
REQ-024 The last-granted pointer shall update only when a grant is issued.

Reset
REQ-025 While resetn=0 at a clock edge:
  - grant, put, data, timeout, credit_cnt and the stall counter shall become 0;
  - the state shall become IDLE;
  - the last-granted pointer shall become NUM_REQ-1, so requester 0 wins first.
REQ-026 Reset asserted mid-message shall abandon the message with no further put; the partial message already written to the buffer is not recalled.

Configuration
REQ-027 With macro UART_TX_ARBITER_TIMEOUT_EN defined:
  - a stall counter shall count consecutive XFER cycles with req_valid of the granted requester equal to 0;
  - any granted req_valid=1 shall clear the stall counter;
  - credit stalls shall not be counted;
  - when the count reaches TIMEOUT_CYCLES, the block shall go to IDLE, clear grant and pulse timeout for one cycle.
REQ-028 Without UART_TX_ARBITER_TIMEOUT_EN, no stall counter shall exist, timeout shall be constant 0 and grants shall be held indefinitely.

Verification
REQ-029 Reset, then req_valid=0001 at cycle t with byte 0x41 and last=1 -> grant=0001 at t+1, req_ready[0]=1 at t+1, put=1 with data=0x41 at t+2, grant=0 at t+2.
REQ-030 All four requesters continuously send 2-byte messages -> grant order 0,1,2,3,0 and no interleaving of bytes between messages.
REQ-031 Requester 1 sends 20 bytes with the last flag on byte 20 and empty held 0 -> exactly 16 puts, then req_ready=0; empty=1 for one cycle -> transfer resumes and the remaining 4 bytes are put.
REQ-032 Requester 2 is granted, then holds req_valid=0 for 2000 cycles -> with the macro, timeout=1 for one cycle 1024 cycles after the stall begins and grant=0; without the macro, grant stays 0100.
REQ-033 resetn=0 asserted for one cycle after the 3rd byte of a 5-byte message -> no further put, grant=0, and the next arbitration picks requester 0.
REQ-034 req_valid=1010 arrives while requester 1 holds the grant mid-message -> requester 3 is granted after requester 1's last byte.
